perf_counter_bank: RTL and testbench

Parametrised machine-mode counter bank: mcycle, minstret and the hpm event counters, each a CNT_WIDTH register exposed as two XLEN halves in the CSR map. It is the CSR-side home of the B00–B1F / B80–B9F / C00–C1F / C80–C9F address ranges plus mcountinhibit (0x320) and mcounteren (0x306). It sits beside the CSR file in the commit stage, takes per-cycle event increments from the pipeline (up to FRONTEND_WIDTH per cycle), and answers CSR reads with one-cycle latency.

---
 rtl/perf_counter_bank.sv | 169 ++++++++++++++++
 tb/tb_perf_counter_bank.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Machine-mode performance counter bank: mcycle, minstret and hpm counters with
// CSR access (one-cycle response), mcountinhibit / mcounteren and overflow pulses.
module perf_counter_bank #(
    parameter int XLEN           = 32,
    parameter int CNT_WIDTH      = 64,
    parameter int NB_CNT         = 16,
    parameter int FRONTEND_WIDTH = 2,
    parameter int INC_WIDTH      = $clog2(FRONTEND_WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NB_CNT*INC_WIDTH-1:0] event_inc_i,
    input  logic [1:0]                  priv_i,
    input  logic                        csr_rd_en_i,
    input  logic                        csr_wr_en_i,
    input  logic [11:0]                 csr_addr_i,
    input  logic [XLEN-1:0]             csr_wdata_i,
    output logic                        csr_rvalid_o,
    output logic [XLEN-1:0]             csr_rdata_o,
    output logic                        csr_illegal_o,
    output logic [NB_CNT-1:0]           ovf_o
);

    localparam int HI_W = CNT_WIDTH - XLEN;
    localparam logic [11:0] ADDR_INHIBIT = 12'h320;
    localparam logic [11:0] ADDR_ENABLE  = 12'h306;

    logic [CNT_WIDTH-1:0] cnt_val [NB_CNT];
    logic [NB_CNT-1:0]    inhibit_reg;
    logic [NB_CNT-1:0]    enable_reg;

    logic                 req;
    logic                 m_mode;
    logic                 is_cnt;
    logic                 is_hi;
    logic                 is_shadow;
    logic                 is_inhibit;
    logic                 is_enable;
    logic                 owned;
    logic                 legal;
    logic                 idx_ok;
    logic [4:0]           idx;
    logic [31:0]          enable_ext;
    logic [CNT_WIDTH-1:0] sel_cnt;
    logic [XLEN-1:0]      rd_val;
    logic                 wr_ok;
    logic                 cnt_wr;

    // Fields 0 and 1 have no event source: mcycle counts cycles, time is absent.
    logic unused_fields;
    assign unused_fields = ^event_inc_i[2*INC_WIDTH-1:0];

    always_comb begin
        req        = csr_rd_en_i || csr_wr_en_i;
        m_mode     = (priv_i == 2'b11);
        idx        = csr_addr_i[4:0];
        is_hi      = csr_addr_i[7];
        is_shadow  = (csr_addr_i[11:8] == 4'hC);
        is_inhibit = (csr_addr_i == ADDR_INHIBIT);
        is_enable  = (csr_addr_i == ADDR_ENABLE);
        case (csr_addr_i[11:5])
            7'h58, 7'h5C, 7'h60, 7'h64: is_cnt = 1'b1;
            default:                    is_cnt = 1'b0;
        endcase
        owned      = is_cnt || is_inhibit || is_enable;
        idx_ok     = int'(idx) < NB_CNT;
        enable_ext = 32'(enable_reg);

        legal = 1'b0;
        if (is_cnt) begin
            if (!idx_ok)
                legal = 1'b0;
            else if (m_mode)
                legal = !(csr_wr_en_i && is_shadow);
            else
                legal = is_shadow && !csr_wr_en_i && enable_ext[idx];
        end else if (is_inhibit || is_enable) begin
            legal = m_mode;
        end

        sel_cnt = '0;
        for (int i = 0; i < NB_CNT; i++) begin
            if (idx == 5'(i))
                sel_cnt = cnt_val[i];
        end

        rd_val = '0;
        if (is_cnt)
            rd_val = is_hi ? XLEN'(sel_cnt >> XLEN) : sel_cnt[XLEN-1:0];
        else if (is_inhibit)
            rd_val = XLEN'(inhibit_reg);
        else if (is_enable)
            rd_val = XLEN'(enable_reg);

        wr_ok  = csr_wr_en_i && owned && legal;
        cnt_wr = wr_ok && is_cnt;
    end

    // Response reflects the state at the start of the request cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            csr_rvalid_o  <= 1'b0;
            csr_illegal_o <= 1'b0;
            csr_rdata_o   <= '0;
        end else begin
            csr_rvalid_o  <= req && owned;
            csr_illegal_o <= req && owned && !legal;
            csr_rdata_o   <= (req && owned && legal) ? rd_val : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inhibit_reg <= '0;
            enable_reg  <= '0;
        end else if (wr_ok && is_inhibit) begin
            inhibit_reg <= csr_wdata_i[NB_CNT-1:0] & ~NB_CNT'(2);
        end else if (wr_ok && is_enable) begin
            enable_reg  <= csr_wdata_i[NB_CNT-1:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB_CNT; gi++) begin : g_cnt
            if (gi == 1) begin : g_time
                assign cnt_val[gi] = '0;
                assign ovf_o[gi]   = 1'b0;
            end else begin : g_live
                logic [CNT_WIDTH-1:0] cnt_reg;
                logic                 ovf_reg;
                logic [INC_WIDTH-1:0] inc;
                logic                 hit;
                logic [CNT_WIDTH:0]   sum;

                always_comb begin
                    inc = (gi == 0) ? INC_WIDTH'(1) : event_inc_i[gi*INC_WIDTH +: INC_WIDTH];
                    if (inc > INC_WIDTH'(FRONTEND_WIDTH))
                        inc = INC_WIDTH'(FRONTEND_WIDTH);
                    hit = cnt_wr && (idx == 5'(gi));
                    // A CSR write to this counter wins over the cycle's increment.
                    if (inhibit_reg[gi] || hit)
                        inc = '0;
                    sum = {1'b0, cnt_reg} + (CNT_WIDTH+1)'(inc);
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt_reg <= '0;
                        ovf_reg <= 1'b0;
                    end else if (hit) begin
                        if (is_hi)
                            cnt_reg[CNT_WIDTH-1:XLEN] <= csr_wdata_i[HI_W-1:0];
                        else
                            cnt_reg[XLEN-1:0] <= csr_wdata_i;
                        ovf_reg <= 1'b0;
                    end else begin
                        cnt_reg <= sum[CNT_WIDTH-1:0];
                        ovf_reg <= sum[CNT_WIDTH];
                    end
                end

                assign cnt_val[gi] = cnt_reg;
                assign ovf_o[gi]   = ovf_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: directed scenarios plus random CSR traffic, every
// cycle compared against an array-based reference model of the counter bank.
module tb_perf_counter_bank;

    localparam int NB = 16;
    localparam int IW = 2;
    localparam int FW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [NB*IW-1:0] event_inc;
    logic [1:0]     priv;
    logic           rd;
    logic           wr;
    logic [11:0]    addr;
    logic [31:0]    wdata;
    logic           rvalid;
    logic [31:0]    rdata;
    logic           illegal;
    logic [NB-1:0]  ovf;

    always #5 clk = ~clk;

    perf_counter_bank #(
        .XLEN(32), .CNT_WIDTH(64), .NB_CNT(NB), .FRONTEND_WIDTH(FW)
    ) dut (
        .clk(clk), .reset(reset), .event_inc_i(event_inc), .priv_i(priv),
        .csr_rd_en_i(rd), .csr_wr_en_i(wr), .csr_addr_i(addr), .csr_wdata_i(wdata),
        .csr_rvalid_o(rvalid), .csr_rdata_o(rdata), .csr_illegal_o(illegal), .ovf_o(ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [63:0]   m_cnt [NB];
    logic [NB-1:0] m_inh;
    logic [NB-1:0] m_en;
    logic [31:0]   last_rdata;
    logic          last_illegal;
    logic          last_rvalid;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: predict from the model, advance it, then compare after the edge.
    task automatic step();
        logic          e_rv, e_il, is_cnt, is_inh, is_en, hi, shadow, legal, m, req;
        logic [31:0]   e_rd, val;
        logic [NB-1:0] e_ovf;
        logic [63:0]   old;
        int            idx, inc;
        e_rv = 0; e_il = 0; e_rd = 0; e_ovf = '0; val = 0; legal = 0;
        is_cnt = 0; hi = 0; shadow = 0; idx = 0;
        req = rd || wr;
        if (reset) begin
            for (int i = 0; i < NB; i++) m_cnt[i] = 0;
            m_inh = '0;
            m_en  = '0;
        end else begin
            if (addr >= 12'hB00 && addr <= 12'hB1F) begin is_cnt = 1; end
            else if (addr >= 12'hB80 && addr <= 12'hB9F) begin is_cnt = 1; hi = 1; end
            else if (addr >= 12'hC00 && addr <= 12'hC1F) begin is_cnt = 1; shadow = 1; end
            else if (addr >= 12'hC80 && addr <= 12'hC9F) begin is_cnt = 1; shadow = 1; hi = 1; end
            is_inh = (addr == 12'h320);
            is_en  = (addr == 12'h306);
            m = (priv == 2'b11);
            if (is_cnt) begin
                idx = int'(addr[4:0]);
                if (idx < NB) begin
                    val = hi ? m_cnt[idx][63:32] : m_cnt[idx][31:0];
                    if (m) legal = !(wr && shadow);
                    else   legal = shadow && !wr && m_en[idx];
                end
            end else if (is_inh || is_en) begin
                legal = m;
                val = is_inh ? 32'(m_inh) : 32'(m_en);
            end
            e_rv = req && (is_cnt || is_inh || is_en);
            e_il = e_rv && !legal;
            e_rd = (e_rv && legal) ? val : 32'h0;
            for (int i = 0; i < NB; i++) begin
                if (i == 1) continue;
                if (e_rv && legal && wr && is_cnt && idx == i) begin
                    if (hi) m_cnt[i][63:32] = wdata;
                    else    m_cnt[i][31:0]  = wdata;
                end else if (!m_inh[i]) begin
                    inc = (i == 0) ? 1 : int'(event_inc[i*IW +: IW]);
                    if (inc > FW) inc = FW;
                    old = m_cnt[i];
                    m_cnt[i] = old + 64'(inc);
                    e_ovf[i] = (m_cnt[i] < old);
                end
            end
            if (e_rv && legal && wr && is_inh) m_inh = wdata[NB-1:0] & ~16'h0002;
            if (e_rv && legal && wr && is_en)  m_en  = wdata[NB-1:0];
        end
        @(posedge clk);
        #1;
        check_val("rvalid", rvalid, e_rv);
        check_val("illegal", illegal, e_il);
        if (reset || !(wr && !rd)) check_val("rdata", rdata, e_rd);
        check_val("ovf", ovf, e_ovf);
        last_rdata   = rdata;
        last_illegal = illegal;
        last_rvalid  = rvalid;
        if (req && !reset)
            $display("txn rd=%0b wr=%0b priv=%0d addr=%03h wdata=%08h -> rvalid=%0b illegal=%0b rdata=%08h",
                     rd, wr, priv, addr, wdata, rvalid, illegal, rdata);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic access(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
        rd = r; wr = w; addr = a; wdata = d;
        step();
        rd = 0; wr = 0; addr = 12'h000; wdata = 0;
    endtask

    initial begin
        reset = 1; event_inc = '0; priv = 2'b11; rd = 0; wr = 0; addr = 0; wdata = 0;
        for (int i = 0; i < NB; i++) m_cnt[i] = 0;
        m_inh = '0; m_en = '0;
        idle(3);
        check_val("reset_ovf", ovf, 0);
        reset = 0;

        // mcycle: the 10th cycle after release reads 9
        idle(9);
        access(1, 0, 12'hB00, 0);
        check_val("mcycle_10th", last_rdata, 9);
        check_val("mcycle_legal", last_illegal, 0);

        // event counting and saturation of field value 3
        event_inc[3*IW +: IW] = 2'd2;
        idle(5);
        event_inc = '0;
        access(1, 0, 12'hB03, 0);
        check_val("hpm3_x5", last_rdata, 10);
        event_inc[3*IW +: IW] = 2'd3;
        idle(4);
        event_inc = '0;
        access(1, 0, 12'hB03, 0);
        check_val("hpm3_sat", last_rdata, 18);

        // carry from low into high half, then full wrap with overflow pulse
        access(0, 1, 12'hB83, 32'h0);
        access(0, 1, 12'hB03, 32'hFFFF_FFFF);
        event_inc[3*IW +: IW] = 2'd2;
        idle(1);
        event_inc = '0;
        access(1, 0, 12'hB03, 0);
        check_val("carry_lo", last_rdata, 1);
        access(1, 0, 12'hB83, 0);
        check_val("carry_hi", last_rdata, 1);
        access(0, 1, 12'hB83, 32'hFFFF_FFFF);
        access(0, 1, 12'hB03, 32'hFFFF_FFFF);
        event_inc[3*IW +: IW] = 2'd1;
        idle(1);
        check_val("ovf3_pulse", ovf[3], 1);
        event_inc = '0;
        idle(1);
        check_val("ovf3_clear", ovf[3], 0);
        access(1, 0, 12'hB03, 0);
        check_val("wrap_lo", last_rdata, 0);
        access(1, 0, 12'hB83, 0);
        check_val("wrap_hi", last_rdata, 0);

        // write beats same-cycle increment; csrrw returns the old value
        event_inc[2*IW +: IW] = 2'd2;
        access(0, 1, 12'hB02, 32'h100);
        event_inc = '0;
        access(1, 0, 12'hB02, 0);
        check_val("wr_drop_inc", last_rdata, 32'h100);
        access(1, 1, 12'hB02, 32'h55);
        check_val("csrrw_old", last_rdata, 32'h100);
        access(1, 0, 12'hB02, 0);
        check_val("csrrw_new", last_rdata, 32'h55);

        // mcountinhibit freezes mcycle, clearing resumes it
        access(0, 1, 12'h320, 32'h1);
        access(0, 1, 12'hB00, 32'h5);
        idle(20);
        access(1, 0, 12'hB00, 0);
        check_val("inhibit_frozen", last_rdata, 5);
        access(0, 1, 12'h320, 32'h0);
        idle(3);
        access(1, 0, 12'hB00, 0);
        check_val("inhibit_resume", last_rdata, 8);

        // privilege and range checks
        access(0, 1, 12'hB03, 32'h1234);
        priv = 2'b00;
        access(1, 0, 12'hC03, 0);
        check_val("u_noen_ill", last_illegal, 1);
        check_val("u_noen_data", last_rdata, 0);
        priv = 2'b11;
        access(0, 1, 12'h306, 32'h8);
        priv = 2'b00;
        access(1, 0, 12'hC03, 0);
        check_val("u_en_ill", last_illegal, 0);
        check_val("u_en_data", last_rdata, 32'h1234);
        access(0, 1, 12'hC03, 32'h0);
        check_val("u_wr_ill", last_illegal, 1);
        priv = 2'b11;
        access(0, 1, 12'hC00, 32'h0);
        check_val("m_wr_shadow_ill", last_illegal, 1);
        access(1, 0, 12'hB03, 0);
        check_val("unchanged", last_rdata, 32'h1234);
        access(1, 0, 12'hB1F, 0);
        check_val("unimpl_ill", last_illegal, 1);
        access(1, 0, 12'h300, 0);
        check_val("not_owned", last_rvalid, 0);

        // request during reset gets no response
        reset = 1;
        access(1, 0, 12'hB00, 0);
        check_val("reset_drop", last_rvalid, 0);
        reset = 0;

        // random traffic
        for (int k = 0; k < 800; k++) begin
            int sel;
            event_inc = NB*IW'($urandom());
            priv = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 7);
            case (sel)
                0: addr = 12'hB00 + 12'($urandom_range(0, 31));
                1: addr = 12'hB80 + 12'($urandom_range(0, 31));
                2: addr = 12'hC00 + 12'($urandom_range(0, 31));
                3: addr = 12'hC80 + 12'($urandom_range(0, 31));
                4: addr = 12'h320;
                5: addr = 12'h306;
                6: addr = 12'hB80 + 12'($urandom_range(0, 15));
                default: addr = 12'($urandom());
            endcase
            case ($urandom_range(0, 2))
                0: wdata = 32'hFFFF_FFFF;
                1: wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: wdata = $urandom();
            endcase
            if (addr == 12'h320) wdata = wdata & 32'h0000_0F00;
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 0; rd = 0; wr = 0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
